// File: rtl/imem_arb_pkg.sv
// Shared types and defaults for the instruction-SRAM arbiter.
// Build option: IMEM_ARB_RR_EN selects round-robin tie breaking; see imem_arb_pick.
package imem_arb_pkg;

   localparam int unsigned DEF_ADDR_W = 6;

   typedef enum logic {
      S_ARB  = 1'b0,
      S_LOCK = 1'b1
   } state_e;

   typedef enum logic [1:0] {
      NONE  = 2'd0,
      FETCH = 2'd1,
      LDR   = 2'd2
   } owner_e;

endpackage

// File: rtl/imem_arb_pick.sv
// Two-way grant logic for the instruction-SRAM arbiter.
// Define IMEM_ARB_RR_EN for round-robin ties; otherwise the loader always wins a tie.
module imem_arb_pick
   import imem_arb_pkg::*;
(
   input  logic   fetch_v_i,
   input  logic   ldr_v_i,
   input  owner_e last_grant_i,
   output owner_e grant_o
);

`ifndef IMEM_ARB_RR_EN
   logic last_grant_unused;
   assign last_grant_unused = ^last_grant_i;
`endif

   // NOTE: grant_o gets its default before any branch so no latch is inferred.
   always_comb begin
      grant_o = NONE;
      if (fetch_v_i && ldr_v_i) begin
`ifdef IMEM_ARB_RR_EN
         grant_o = (last_grant_i == LDR) ? FETCH : LDR;
`else
         grant_o = LDR;
`endif
      end else if (ldr_v_i) begin
         grant_o = LDR;
      end else if (fetch_v_i) begin
         grant_o = FETCH;
      end
   end

endmodule

// File: rtl/imem_arbiter.sv
// Shares one single-port instruction SRAM between core fetch and a loader/debug port.
// Build option: IMEM_ARB_RR_EN (round-robin ties); default build gives the loader priority.
module imem_arbiter
   import imem_arb_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              fetch_req_valid_i,
   output logic              fetch_req_ready_o,
   input  logic [31:0]       fetch_req_addr_i,
   input  logic              fetch_flush_i,
   output logic              fetch_rsp_valid_o,
   output logic [31:0]       fetch_rsp_addr_o,
   output logic [31:0]       fetch_rsp_data_o,
   input  logic              ldr_req_valid_i,
   output logic              ldr_req_ready_o,
   input  logic              ldr_req_we_i,
   input  logic [31:0]       ldr_req_addr_i,
   input  logic [31:0]       ldr_req_wdata_i,
   input  logic              ldr_lock_i,
   output logic              ldr_rsp_valid_o,
   output logic [31:0]       ldr_rsp_data_o,
   output logic              mem_en_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [31:0]       mem_wdata_o,
   input  logic [31:0]       mem_rdata_i
);

   state_e      state_q, state_d;
   owner_e      last_grant_q, last_grant_d;
   owner_e      grant;
   logic        fetch_pend_q, fetch_pend_d;
   logic        ldr_pend_q, ldr_pend_d;
   logic [31:0] fetch_addr_q, fetch_addr_d;
   logic        fetch_cand;
   logic        ldr_cand;
   logic        ldr_addr_unused;

   // A lock request stops new fetch issue so back-to-back fetches can never starve the lock.
   assign fetch_cand = rst_ni & fetch_req_valid_i & ~fetch_flush_i & ~ldr_lock_i
                       & (state_q == S_ARB);
   assign ldr_cand   = rst_ni & ldr_req_valid_i;

   assign ldr_addr_unused = ^{ldr_req_addr_i[31:ADDR_W+2], ldr_req_addr_i[1:0]};

   imem_arb_pick u_pick (
      .fetch_v_i    (fetch_cand),
      .ldr_v_i      (ldr_cand),
      .last_grant_i (last_grant_q),
      .grant_o      (grant)
   );

   always_comb begin
      state_d           = state_q;
      last_grant_d      = last_grant_q;
      fetch_pend_d      = 1'b0;
      ldr_pend_d        = 1'b0;
      fetch_addr_d      = fetch_addr_q;
      fetch_req_ready_o = 1'b0;
      ldr_req_ready_o   = 1'b0;
      mem_en_o          = 1'b0;
      mem_we_o          = 1'b0;
      mem_addr_o        = '0;
      mem_wdata_o       = '0;

      case (state_q)
         S_ARB:   if (ldr_lock_i && !fetch_pend_q) state_d = S_LOCK;
         S_LOCK:  if (!ldr_lock_i) state_d = S_ARB;
         default: state_d = S_ARB;
      endcase

      case (grant)
         FETCH: begin
            fetch_req_ready_o = 1'b1;
            mem_en_o          = 1'b1;
            mem_addr_o        = fetch_req_addr_i[ADDR_W+1:2];
            fetch_pend_d      = 1'b1;
            fetch_addr_d      = fetch_req_addr_i;
            last_grant_d      = FETCH;
         end
         LDR: begin
            ldr_req_ready_o = 1'b1;
            mem_en_o        = 1'b1;
            mem_we_o        = ldr_req_we_i;
            mem_addr_o      = ldr_req_addr_i[ADDR_W+1:2];
            mem_wdata_o     = ldr_req_we_i ? ldr_req_wdata_i : '0;
            ldr_pend_d      = ~ldr_req_we_i;
            last_grant_d    = LDR;
         end
         default: ;
      endcase
   end

   // Flush kills the response arriving now; no fetch issues under flush, so none arrives next cycle.
   assign fetch_rsp_valid_o = fetch_pend_q & ~fetch_flush_i;
   assign fetch_rsp_addr_o  = fetch_rsp_valid_o ? fetch_addr_q : '0;
   assign fetch_rsp_data_o  = fetch_rsp_valid_o ? mem_rdata_i : '0;
   assign ldr_rsp_valid_o   = ldr_pend_q;
   assign ldr_rsp_data_o    = ldr_pend_q ? mem_rdata_i : '0;

   // NOTE: non-blocking assignments so every flop samples the pre-edge value of its _d.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= S_ARB;
         last_grant_q <= FETCH;
         fetch_pend_q <= 1'b0;
         ldr_pend_q   <= 1'b0;
         fetch_addr_q <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         fetch_pend_q <= fetch_pend_d;
         ldr_pend_q   <= ldr_pend_d;
         fetch_addr_q <= fetch_addr_d;
      end
   end

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: table vectors, directed corner sequences and
// randomized traffic checked against a transaction-level model with its own memory image.
module tb_imem_arbiter;

   localparam int ADDR_W = 6;
   localparam int DEPTH  = 64;
`ifdef IMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   typedef struct {
      logic        fv;
      logic [31:0] faddr;
      logic        flush;
      logic        lv;
      logic        lwe;
      logic [31:0] laddr;
      logic [31:0] lwdata;
      logic        lock;
   } stim_t;

   typedef struct {
      stim_t       in;
      logic        fr;
      logic        lr;
      logic [5:0]  addr;
   } vec_t;

   typedef struct {
      bit          is_fetch;
      logic [31:0] addr;
      logic [31:0] data;
   } rsp_t;

   logic              clk_i;
   logic              rst_ni;
   logic              fetch_req_valid_i;
   logic              fetch_req_ready_o;
   logic [31:0]       fetch_req_addr_i;
   logic              fetch_flush_i;
   logic              fetch_rsp_valid_o;
   logic [31:0]       fetch_rsp_addr_o;
   logic [31:0]       fetch_rsp_data_o;
   logic              ldr_req_valid_i;
   logic              ldr_req_ready_o;
   logic              ldr_req_we_i;
   logic [31:0]       ldr_req_addr_i;
   logic [31:0]       ldr_req_wdata_i;
   logic              ldr_lock_i;
   logic              ldr_rsp_valid_o;
   logic [31:0]       ldr_rsp_data_o;
   logic              mem_en_o;
   logic              mem_we_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic [31:0]       mem_wdata_o;
   logic [31:0]       mem_rdata_i;

   imem_arbiter #(.ADDR_W(ADDR_W)) dut (
      .clk_i             (clk_i),
      .rst_ni            (rst_ni),
      .fetch_req_valid_i (fetch_req_valid_i),
      .fetch_req_ready_o (fetch_req_ready_o),
      .fetch_req_addr_i  (fetch_req_addr_i),
      .fetch_flush_i     (fetch_flush_i),
      .fetch_rsp_valid_o (fetch_rsp_valid_o),
      .fetch_rsp_addr_o  (fetch_rsp_addr_o),
      .fetch_rsp_data_o  (fetch_rsp_data_o),
      .ldr_req_valid_i   (ldr_req_valid_i),
      .ldr_req_ready_o   (ldr_req_ready_o),
      .ldr_req_we_i      (ldr_req_we_i),
      .ldr_req_addr_i    (ldr_req_addr_i),
      .ldr_req_wdata_i   (ldr_req_wdata_i),
      .ldr_lock_i        (ldr_lock_i),
      .ldr_rsp_valid_o   (ldr_rsp_valid_o),
      .ldr_rsp_data_o    (ldr_rsp_data_o),
      .mem_en_o          (mem_en_o),
      .mem_we_o          (mem_we_o),
      .mem_addr_o        (mem_addr_o),
      .mem_wdata_o       (mem_wdata_o),
      .mem_rdata_i       (mem_rdata_i)
   );

   initial clk_i = 1'b0;
   always #5 clk_i = ~clk_i;

   // Synchronous single-port SRAM: read data valid the cycle after mem_en_o.
   logic [31:0] sram [DEPTH];
   always @(posedge clk_i) begin
      if (mem_en_o) begin
         if (mem_we_o) sram[mem_addr_o] <= mem_wdata_o;
         else          mem_rdata_i      <= sram[mem_addr_o];
      end
   end

   int n_checks = 0;
   int n_err    = 0;

   // Reference model: lock flag, who won last, responses in flight, and its own memory image.
   bit          m_locked;
   bit          m_last_ldr;
   rsp_t        m_q[$];
   logic [31:0] ref_mem [DEPTH];
   logic [31:0] preload [DEPTH];

   logic              s_fr, s_lr, s_en, s_we, s_frv, s_lrv;
   logic [ADDR_W-1:0] s_addr;
   logic [31:0]       s_fra, s_frd;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic stim_t mk(input logic fv, input logic [31:0] fa, input logic fl,
                                input logic lv, input logic we, input logic [31:0] la,
                                input logic [31:0] wd, input logic lk);
      stim_t s;
      s.fv = fv; s.faddr = fa; s.flush = fl; s.lv = lv;
      s.lwe = we; s.laddr = la; s.lwdata = wd; s.lock = lk;
      return s;
   endfunction

   function automatic int unsigned word_of(input logic [31:0] byte_addr);
      return (byte_addr / 4) % DEPTH;
   endfunction

   task automatic drive(input stim_t s);
      fetch_req_valid_i = s.fv;
      fetch_req_addr_i  = s.faddr;
      fetch_flush_i     = s.flush;
      ldr_req_valid_i   = s.lv;
      ldr_req_we_i      = s.lwe;
      ldr_req_addr_i    = s.laddr;
      ldr_req_wdata_i   = s.lwdata;
      ldr_lock_i        = s.lock;
   endtask

   // One clock cycle: drive, predict, compare at the falling edge, then advance the model.
   task automatic cycle(input stim_t s);
      rsp_t        cur;
      bit          have_cur, fetch_pend, want_f, want_l, exp_frv, exp_lrv;
      int          win;
      int unsigned widx;
      drive(s);
      have_cur   = (m_q.size() != 0);
      cur        = have_cur ? m_q[0] : '{is_fetch: 1'b0, addr: '0, data: '0};
      fetch_pend = have_cur && cur.is_fetch;
      want_f     = s.fv && !m_locked && !s.flush && !s.lock;
      want_l     = s.lv;
      win        = 0;
      if (want_f && want_l) win = RR ? (m_last_ldr ? 1 : 2) : 2;
      else if (want_l)      win = 2;
      else if (want_f)      win = 1;
      widx    = (win == 2) ? word_of(s.laddr) : word_of(s.faddr);
      exp_frv = fetch_pend && !s.flush;
      exp_lrv = have_cur && !cur.is_fetch;

      @(negedge clk_i);
      s_fr = fetch_req_ready_o; s_lr = ldr_req_ready_o; s_en = mem_en_o; s_we = mem_we_o;
      s_addr = mem_addr_o; s_frv = fetch_rsp_valid_o; s_fra = fetch_rsp_addr_o;
      s_frd = fetch_rsp_data_o; s_lrv = ldr_rsp_valid_o;
      check("fetch_req_ready", s_fr, 32'(win == 1));
      check("ldr_req_ready", s_lr, 32'(win == 2));
      check("mem_en", s_en, 32'(win != 0));
      check("mem_we", s_we, 32'(win == 2 && s.lwe));
      if (win != 0) check("mem_addr", 32'(s_addr), widx);
      if (win == 2 && s.lwe) check("mem_wdata", mem_wdata_o, s.lwdata);
      check("fetch_rsp_valid", s_frv, 32'(exp_frv));
      if (exp_frv) begin
         check("fetch_rsp_addr", s_fra, cur.addr);
         check("fetch_rsp_data", s_frd, cur.data);
      end
      check("ldr_rsp_valid", s_lrv, 32'(exp_lrv));
      if (exp_lrv) check("ldr_rsp_data", ldr_rsp_data_o, cur.data);

      @(posedge clk_i);
      #1;
      if (have_cur) m_q.delete(0);
      if (win == 1) begin
         m_q.push_back('{is_fetch: 1'b1, addr: s.faddr, data: ref_mem[widx]});
         m_last_ldr = 1'b0;
      end else if (win == 2) begin
         m_last_ldr = 1'b1;
         if (s.lwe) ref_mem[widx] = s.lwdata;
         else       m_q.push_back('{is_fetch: 1'b0, addr: s.laddr, data: ref_mem[widx]});
      end
      m_locked = m_locked ? s.lock : (s.lock && !fetch_pend);
   endtask

   // One-cycle reset with both requesters active: every output must still read zero.
   task automatic do_reset();
      drive(mk(1'b1, 32'h44, 1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b0));
      rst_ni = 1'b0;
      @(negedge clk_i);
      check("rst_ctrl_outs", {26'd0, fetch_req_ready_o, ldr_req_ready_o, fetch_rsp_valid_o,
                              ldr_rsp_valid_o, mem_en_o, mem_we_o}, 32'd0);
      check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
      check("rst_mem_wdata", mem_wdata_o, 32'd0);
      check("rst_fetch_rsp_addr", fetch_rsp_addr_o, 32'd0);
      check("rst_fetch_rsp_data", fetch_rsp_data_o, 32'd0);
      check("rst_ldr_rsp_data", ldr_rsp_data_o, 32'd0);
      @(posedge clk_i);
      #1;
      rst_ni = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0, 0));
      m_locked   = 1'b0;
      m_last_ldr = 1'b0;
      m_q.delete();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      vec_t  tbl [12];
      stim_t idle;
      stim_t rs;
      bit    lock_state;

      idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
      do_reset();

      for (int i = 0; i < DEPTH; i++) begin
         preload[i] = $urandom;
         cycle(mk(0, 0, 0, 1, 1, 32'(i * 4), preload[i], 0));
      end
      cycle(idle);

      tbl[0]  = '{mk(1, 32'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 6'd0};
      tbl[1]  = '{mk(0, 0, 0, 1, 0, 32'h104, 0, 0), 1'b0, 1'b1, 6'd1};
      tbl[2]  = '{mk(1, 32'h0B, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 6'd2};
      tbl[3]  = '{mk(1, 32'h0C, 1, 0, 0, 0, 0, 0), 1'b0, 1'b0, 6'd0};
      tbl[4]  = '{mk(0, 0, 0, 1, 1, 32'h3C, 32'h0BADF00D, 0), 1'b0, 1'b1, 6'd15};
      tbl[5]  = '{idle, 1'b0, 1'b0, 6'd0};
      tbl[6]  = '{mk(1, 32'h20, 0, 1, 0, 32'h24, 0, 0), RR, !RR, RR ? 6'd8 : 6'd9};
      tbl[7]  = '{mk(1, 32'h28, 0, 1, 0, 32'h2C, 0, 0), 1'b0, 1'b1, 6'd11};
      tbl[8]  = '{mk(1, 32'h30, 0, 1, 0, 32'h34, 0, 1), 1'b0, 1'b1, 6'd13};
      tbl[9]  = '{mk(1, 32'h00, 0, 0, 0, 0, 0, 1), 1'b0, 1'b0, 6'd0};
      tbl[10] = '{mk(1, 32'h00, 0, 0, 0, 0, 0, 0), 1'b0, 1'b0, 6'd0};
      tbl[11] = '{mk(1, 32'h00, 0, 0, 0, 0, 0, 0), 1'b1, 1'b0, 6'd0};
      for (int i = 0; i < 12; i++) begin
         cycle(tbl[i].in);
         check($sformatf("tbl%0d_fetch_ready", i), s_fr, tbl[i].fr);
         check($sformatf("tbl%0d_ldr_ready", i), s_lr, tbl[i].lr);
         if (tbl[i].fr || tbl[i].lr)
            check($sformatf("tbl%0d_mem_addr", i), 32'(s_addr), 32'(tbl[i].addr));
      end
      cycle(idle);

      // Back-to-back fetches of words 0..2.
      for (int k = 0; k < 4; k++) begin
         cycle((k < 3) ? mk(1, 32'(k * 4), 0, 0, 0, 0, 0, 0) : idle);
         if (k > 0) begin
            check("b2b_rsp_valid", s_frv, 32'd1);
            check("b2b_rsp_addr", s_fra, 32'((k - 1) * 4));
            check("b2b_rsp_data", s_frd, preload[k - 1]);
         end
      end

      // Loader write then fetch of the same word.
      cycle(mk(0, 0, 0, 1, 1, 32'h0C, 32'hDEADBEEF, 0));
      check("ldw_mem_we", s_we, 32'd1);
      cycle(mk(1, 32'h0C, 0, 0, 0, 0, 0, 0));
      check("ldw_fetch_we", s_we, 32'd0);
      cycle(idle);
      check("ldw_rsp_valid", s_frv, 32'd1);
      check("ldw_rsp_data", s_frd, 32'hDEADBEEF);

      // Flush right after a fetch grant, then a normal fetch.
      cycle(mk(1, 32'h10, 0, 0, 0, 0, 0, 0));
      check("flush_grant", s_fr, 32'd1);
      cycle(mk(1, 32'h14, 1, 0, 0, 0, 0, 0));
      check("flush_rsp_killed", s_frv, 32'd0);
      check("flush_no_ready", s_fr, 32'd0);
      cycle(idle);
      check("flush_no_late_rsp", s_frv, 32'd0);
      cycle(mk(1, 32'h40, 0, 0, 0, 0, 0, 0));
      check("post_flush_grant", s_fr, 32'd1);
      cycle(idle);
      check("post_flush_rsp_valid", s_frv, 32'd1);
      check("post_flush_rsp_addr", s_fra, 32'h40);
      check("post_flush_rsp_data", s_frd, preload[16]);

      // Lock held five cycles against a waiting fetch.
      cycle(idle);
      for (int k = 0; k < 5; k++) begin
         cycle(mk(1, 32'h50, 0, 0, 0, 0, 0, 1));
         check($sformatf("lock%0d_fetch_ready", k), s_fr, 32'd0);
      end
      cycle(mk(1, 32'h50, 0, 0, 0, 0, 0, 0));
      check("unlock_same_cycle_ready", s_fr, 32'd0);
      cycle(mk(1, 32'h50, 0, 0, 0, 0, 0, 0));
      check("unlock_next_cycle_ready", s_fr, 32'd1);
      cycle(idle);

      // Tie pattern from a fresh reset.
      do_reset();
      for (int k = 0; k < 4; k++) begin
         cycle(mk(1, 32'(k * 4), 0, 1, 0, 32'(32'h80 + k * 4), 0, 0));
         check($sformatf("tie%0d_ldr_ready", k), s_lr, RR ? 32'(k % 2 == 0) : 32'd1);
         check($sformatf("tie%0d_fetch_ready", k), s_fr, RR ? 32'(k % 2 == 1) : 32'd0);
      end
      cycle(idle);

      // Reset right after a fetch grant.
      cycle(mk(1, 32'h20, 0, 0, 0, 0, 0, 0));
      check("rst_mid_grant", s_fr, 32'd1);
      do_reset();
      cycle(idle);
      check("rst_mid_no_rsp", s_frv, 32'd0);

      lock_state = 1'b0;
      for (int c = 0; c < 400; c++) begin
         if ($urandom_range(0, 19) == 0) lock_state = !lock_state;
         rs = mk($urandom_range(0, 3) != 0, $urandom, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 2) == 0, $urandom, $urandom,
                 lock_state);
         cycle(rs);
      end
      cycle(idle);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

// File: doc/imem_arbiter.md
IMEM_ARBITER -- requirements
Module: imem_arbiter

Interface
REQ-001 SHALL use one clock, clk_i; reset rst_ni is asynchronous and active-low.
REQ-002 Parameter ADDR_W, default 6, word-address width of the instruction SRAM (64 words).
REQ-003 clk_i  in  1  rising-edge clock.
REQ-004 rst_ni  in  1  async active-low reset.
REQ-005 fetch_req_valid_i  in  1  core fetch request.
REQ-006 fetch_req_ready_o  out  1  fetch request accepted this cycle.
REQ-007 fetch_req_addr_i  in  32  fetch byte address (PC).
REQ-008 fetch_flush_i  in  1  discard in-flight fetch response; block new fetch issue.
REQ-009 fetch_rsp_valid_o  out  1  fetch response valid.
REQ-010 fetch_rsp_addr_o  out  32  PC of returned instruction.
REQ-011 fetch_rsp_data_o  out  32  returned instruction.
REQ-012 ldr_req_valid_i  in  1  loader/debug request.
REQ-013 ldr_req_ready_o  out  1  loader request accepted this cycle.
REQ-014 ldr_req_we_i  in  1  1 = write, 0 = read.
REQ-015 ldr_req_addr_i  in  32  loader byte address.
REQ-016 ldr_req_wdata_i  in  32  loader write data.
REQ-017 ldr_lock_i  in  1  loader requests exclusive ownership.
REQ-018 ldr_rsp_valid_o  out  1  loader read data valid.
REQ-019 ldr_rsp_data_o  out  32  loader read data.
REQ-020 mem_en_o  out  1  SRAM access strobe.
REQ-021 mem_we_o  out  1  SRAM write enable.
REQ-022 mem_addr_o  out  ADDR_W  SRAM word address.
REQ-023 mem_wdata_o  out  32  SRAM write data.
REQ-024 mem_rdata_i  in  32  SRAM read data, one cycle after mem_en_o.

Function
REQ-025 FSM states S_ARB (shared) and S_LOCK (loader exclusive); S_ARB -> S_LOCK when ldr_lock_i=1 and no fetch response pending; S_LOCK -> S_ARB when ldr_lock_i=0.
REQ-026 At most one request granted per cycle; grant drives mem_en_o=1 combinationally in the same cycle; ready_o equals grant.
REQ-027 mem_addr_o = granted addr[ADDR_W+1:2]; addr[1:0] ignored; upper bits ignored (aliasing).
REQ-028 Read response latency exactly 1 cycle: rsp_valid_o pulses the cycle after grant, data = mem_rdata_i, fetch_rsp_addr_o = registered request address.
REQ-029 Loader writes drive mem_we_o=1 and produce no response.
REQ-030 Responses have no backpressure; fully pipelined, back-to-back grants allowed every cycle.
REQ-031 fetch_flush_i=1: fetch_req_ready_o=0 that cycle; a fetch response due this cycle or next is suppressed (fetch_rsp_valid_o=0).
REQ-032 In S_LOCK fetch_req_ready_o=0; loader granted whenever valid.
REQ-033 Simultaneous valid in S_ARB resolved per REQ-041/042; last_grant register updated on every grant.
REQ-034 Lock requested while fetch response pending: loader keeps being arbitrated normally until response returns, then lock is entered.

Reset
REQ-035 Reset: all outputs 0, state S_ARB, pending responses discarded, last_grant = FETCH.
REQ-036 Reset asserted mid-access: response for that access never appears after release.

Configuration
REQ-037 Macro IMEM_ARB_RR_EN selects the tie policy in S_ARB.
REQ-041 With IMEM_ARB_RR_EN defined: round-robin, requester not granted last wins a tie.
REQ-042 Without it: fixed priority, loader always wins a tie.

Structure
REQ-043 Package imem_arb_pkg holds state_e (S_ARB, S_LOCK), owner_e (NONE, FETCH, LDR), default ADDR_W.
REQ-044 Sub-module imem_arb_pick: 2-way grant logic (policy + last_grant).

Verification
REQ-045 Fetch-only addr 0x00,0x04,0x08 back-to-back -> three consecutive rsp pulses, data IMem[0..2], rsp_addr 0x00,0x04,0x08.
REQ-046 Loader write 0x0C=0xDEADBEEF then fetch 0x0C -> mem_we_o one cycle, fetch_rsp_data_o=0xDEADBEEF.
REQ-047 Both valid 4 cycles with RR on -> grants alternate L,F,L,F; RR off -> L,L,L,L, fetch_req_ready_o=0.
REQ-048 Fetch 0x10 granted, fetch_flush_i=1 next cycle -> no fetch_rsp_valid_o; fetch 0x40 after flush returns normally.
REQ-049 ldr_lock_i=1 for 5 cycles with fetch valid -> fetch_req_ready_o=0 throughout, S_ARB resumes the cycle after ldr_lock_i=0.
REQ-050 rst_ni low for one cycle right after fetch grant -> no response, all outputs 0.
